// File: rtl/dual_fetch_queue.sv
// dual_fetch_queue: two-wide in-order instruction buffer between fetch and dual-issue decode
module dual_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid_a,
    input  logic [XLEN-1:0]          in_instr_a,
    input  logic [XLEN-1:0]          in_pc_a,
    input  logic                     in_valid_b,
    input  logic [XLEN-1:0]          in_instr_b,
    input  logic [XLEN-1:0]          in_pc_b,
    output logic                     in_ready,
    output logic                     out_valid_a,
    output logic [XLEN-1:0]          out_instr_a,
    output logic [XLEN-1:0]          out_pc_a,
    output logic                     out_valid_b,
    output logic [XLEN-1:0]          out_instr_b,
    output logic [XLEN-1:0]          out_pc_b,
    input  logic [1:0]               deq_cnt,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_instr [DEPTH];
    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [AW-1:0]   r_rd, r_wr;
    logic [CW-1:0]   r_count;

    logic            w_enq_ok;
    logic [1:0]      w_enq_n, w_deq_req, w_deq;
    logic [AW-1:0]   w_wr_b, w_rd_b;

    assign in_ready  = r_count <= CW'(DEPTH - 2);
    assign w_enq_ok  = in_ready & ~flush;
    assign w_enq_n   = w_enq_ok ? {1'b0, in_valid_a} + {1'b0, in_valid_b} : 2'd0;
    assign w_deq_req = deq_cnt[1] ? 2'd2 : {1'b0, deq_cnt[0]};
    // a request larger than the occupancy can only happen with count < 2
    assign w_deq     = (CW'(w_deq_req) > r_count) ? r_count[1:0] : w_deq_req;
    assign w_wr_b    = r_wr + AW'(in_valid_a);
    assign w_rd_b    = r_rd + AW'(1);
    assign count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= r_rd + AW'(w_deq);
            r_wr    <= r_wr + AW'(w_enq_n);
            r_count <= r_count + CW'(w_enq_n) - CW'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_ok && in_valid_a) begin
            r_instr[r_wr] <= in_instr_a;
            r_pc[r_wr]    <= in_pc_a;
        end
        if (w_enq_ok && in_valid_b) begin
            r_instr[w_wr_b] <= in_instr_b;
            r_pc[w_wr_b]    <= in_pc_b;
        end
    end

    assign out_valid_a = r_count != '0;
    assign out_valid_b = r_count >= CW'(2);
    assign out_instr_a = out_valid_a ? r_instr[r_rd]   : '0;
    assign out_pc_a    = out_valid_a ? r_pc[r_rd]      : '0;
    assign out_instr_b = out_valid_b ? r_instr[w_rd_b] : '0;
    assign out_pc_b    = out_valid_b ? r_pc[w_rd_b]    : '0;
endmodule
